traffic_light_monitor: RTL and testbench
========================================

// Module: traffic_light_monitor
// PURPOSE
//  Passive checker on the consumer side of the Traffic_sys light bus: samples north/south/east/west
//  light outputs every clk, tracks each direction's colour phase, flags unsafe or malformed signalling.
//  Sits beside the controller in system and bench; drives sticky error flags only, never the lights.
//  Light encoding: bit[2]=RED, bit[1]=YELLOW, bit[0]=GREEN, exactly one hot. Axes: N/S and E/W.
// PARAMETERS
//  MIN_GREEN   5   minimum legal green dwell, cycles
//  MAX_GREEN   20  maximum legal green dwell, cycles
//  YELLOW_LEN  3   exact required yellow dwell, cycles
//  CNT_W       8   dwell counter width; saturates at 2**CNT_W-1 (must exceed MAX_GREEN+1)
// PORTS
//  clk          in   1  system clock, rising edge
//  reset_n      in   1  asynchronous active-low reset
//  north_light  in   3  observed north light
//  south_light  in   3  observed south light
//  east_light   in   3  observed east light
//  west_light   in   3  observed west light
//  clear        in   1  sync clear of sticky flags and err_dir
//  err_encoding out  1  sticky: some light not one-hot (incl. 3'b000)
//  err_conflict out  1  sticky: an N/S light and an E/W light both non-RED
//  err_sequence out  1  sticky: illegal colour transition
//  err_timing   out  1  sticky: dwell-time violation
//  err_any      out  1  OR of the four flags (registered)
//  err_dir      out  4  {W,E,S,N}: directions involved in the first error since reset/clear
// BEHAVIOUR
//  - Reset: all outputs 0, every direction state UNKNOWN, counters 0, prev registers RED.
//  - Violation present at rising edge t -> flag high from edge t (visible after t); one registered stage.
//  - Per-direction FSM (sub-module): UNKNOWN, RED, GREEN, YELLOW. UNKNOWN->RED on first sampled RED.
//    Legal moves: R->G, G->Y, Y->R, hold. G->R, Y->G, R->Y set err_sequence; state follows input.
//  - Sequence/timing checks suppressed in UNKNOWN; encoding/conflict checks always active.
//  - Malformed sample: err_encoding, FSM and counter hold previous value.
//  - Dwell counter: 1 on first cycle of a colour, +1 per held cycle, saturating.
//  - G->Y with count <MIN_GREEN or >MAX_GREEN: err_timing. Green still held at count==MAX_GREEN+1:
//    err_timing immediately (once per phase). Y->R with count != YELLOW_LEN: err_timing.
//  - err_dir latched only while all flags clear; multiple offenders same cycle -> OR of all bits.
//  - clear and new violation same edge: violation wins (flag/err_dir set by new event).
//  - Reset mid-phase: everything back to reset values; monitoring restarts from UNKNOWN.
// CONFIGURATION
//  TRAFFIC_MON_CYCLE_CNT_EN defined: extra output cycle_cnt[15:0], +1 on each north Y->R transition
//    ending a phase with no error raised during it; wraps 16'hFFFF->0; reset 0; unaffected by clear.
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  traffic_pkg: RED/YELLOW/GREEN encodings, light_state_t enum (UNKNOWN,RED,GREEN,YELLOW).
//  Sub-module light_dir_checker (x4): FSM, dwell counter, prev register; outputs seq/timing/enc pulses.
//  Top: conflict compare across axes, sticky flags, err_dir, optional cycle_cnt.
// TESTING
//  1 reset_n=0 mid-run, lights random -> all outputs 0; after release no flags until a violation.
//  2 N/S: G 10, Y 3, R; then E/W: G 10, Y 3, R (others RED) -> no flags; cycle_cnt=1 with macro.
//  3 north=3'b011 for one cycle -> err_encoding=1, err_dir=4'b0001, err_any=1 next cycle.
//  4 north=GREEN with east=GREEN -> err_conflict=1, err_dir=4'b0101.
//  5 north Y held 2 cycles then R -> err_timing; separate run green 21 cycles -> err_timing at 21st.
//  6 north G->R directly -> err_sequence; clear same edge as new east Y->G -> flags stay set, err_dir=4'b0100.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared light encodings and per-direction state type for the traffic light bus monitor.
package traffic_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  typedef enum logic [1:0] {
    ST_UNKNOWN,
    ST_RED,
    ST_GREEN,
    ST_YELLOW
  } light_state_t;

  // Maps a raw light sample to a colour; anything not one-hot comes back as ST_UNKNOWN.
  function automatic light_state_t colour_of(input logic [2:0] light);
    case (light)
      LIGHT_RED:    return ST_RED;
      LIGHT_GREEN:  return ST_GREEN;
      LIGHT_YELLOW: return ST_YELLOW;
      default:      return ST_UNKNOWN;
    endcase
  endfunction

endpackage

// File: rtl/light_dir_checker.sv
// Per-direction colour FSM with dwell counter; emits single-cycle encoding/sequence/timing pulses.
// TRAFFIC_MON_CYCLE_CNT_EN adds the y2r pulse used by the top-level phase counter.
//
//   state      | meaning
//   ST_UNKNOWN | no RED seen since reset; sequence and timing checks suppressed
//   ST_RED     | light is red
//   ST_GREEN   | light is green
//   ST_YELLOW  | light is yellow
module light_dir_checker
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = 5,
  parameter int MAX_GREEN  = 20,
  parameter int YELLOW_LEN = 3,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] light,
  output logic       enc_err,
  output logic       seq_err,
  output logic       tim_err
`ifdef TRAFFIC_MON_CYCLE_CNT_EN
  , output logic     y2r
`endif
);

  localparam logic [CNT_W-1:0] CNT_SAT    = '1;
  localparam logic [CNT_W-1:0] MIN_C      = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MAX_C      = CNT_W'(MAX_GREEN);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(MAX_GREEN + 1);
  localparam logic [CNT_W-1:0] YELLOW_C   = CNT_W'(YELLOW_LEN);

  light_state_t     state, state_nxt, col;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       prev, prev_nxt;
  logic             y2r_int;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_UNKNOWN;
      cnt   <= '0;
      prev  <= LIGHT_RED;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      prev  <= prev_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    prev_nxt  = prev;
    enc_err   = 1'b0;
    seq_err   = 1'b0;
    tim_err   = 1'b0;
    y2r_int   = 1'b0;
    col       = colour_of(light);
    if (col == ST_UNKNOWN) begin
      enc_err = 1'b1;
    end else begin
      prev_nxt = light;
      if (light != prev)       cnt_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
      else if (cnt != CNT_SAT) cnt_nxt = cnt + 1'b1;
      // Once known, prev always matches state, so cnt is the dwell of the current colour.
      case (state)
        ST_UNKNOWN: if (col == ST_RED) state_nxt = ST_RED;
        ST_RED: begin
          if (col == ST_YELLOW) seq_err = 1'b1;
          state_nxt = col;
        end
        ST_GREEN: begin
          if (col == ST_RED) seq_err = 1'b1;
          if (col == ST_YELLOW && (cnt < MIN_C || cnt > MAX_C)) tim_err = 1'b1;
          if (col == ST_GREEN && cnt_nxt == TIMEOUT_C) tim_err = 1'b1;
          state_nxt = col;
        end
        ST_YELLOW: begin
          if (col == ST_GREEN) seq_err = 1'b1;
          if (col == ST_RED) begin
            y2r_int = 1'b1;
            if (cnt != YELLOW_C) tim_err = 1'b1;
          end
          state_nxt = col;
        end
        default: state_nxt = ST_UNKNOWN;
      endcase
    end
  end

`ifdef TRAFFIC_MON_CYCLE_CNT_EN
  assign y2r = y2r_int;
`endif

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive light-bus checker: cross-axis conflict, sticky error flags and first-offender err_dir.
// TRAFFIC_MON_CYCLE_CNT_EN adds cycle_cnt, counting clean north yellow-to-red phase ends.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = 5,
  parameter int MAX_GREEN  = 20,
  parameter int YELLOW_LEN = 3,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  north_light,
  input  logic [2:0]  south_light,
  input  logic [2:0]  east_light,
  input  logic [2:0]  west_light,
  input  logic        clear,
  output logic        err_encoding,
  output logic        err_conflict,
  output logic        err_sequence,
  output logic        err_timing,
  output logic        err_any,
  output logic [3:0]  err_dir
`ifdef TRAFFIC_MON_CYCLE_CNT_EN
  , output logic [15:0] cycle_cnt
`endif
);

  logic [11:0] lights;
  logic [3:0]  enc_v, seq_v, tim_v, nonred, offenders, dir_nxt;
  logic        conflict, viol;
  logic        enc_nxt, con_nxt, seq_nxt, tim_nxt;
`ifdef TRAFFIC_MON_CYCLE_CNT_EN
  logic [3:0]  y2r_v;
  logic        phase_err;
`endif

  assign lights = {west_light, east_light, south_light, north_light};

  for (genvar i = 0; i < 4; i++) begin : g_dir
    assign nonred[i] = (lights[3*i +: 3] != LIGHT_RED);

    light_dir_checker #(
      .MIN_GREEN  (MIN_GREEN),
      .MAX_GREEN  (MAX_GREEN),
      .YELLOW_LEN (YELLOW_LEN),
      .CNT_W      (CNT_W)
    ) u_dir (
      .clk     (clk),
      .reset_n (reset_n),
      .light   (lights[3*i +: 3]),
      .enc_err (enc_v[i]),
      .seq_err (seq_v[i]),
      .tim_err (tim_v[i])
`ifdef TRAFFIC_MON_CYCLE_CNT_EN
      , .y2r   (y2r_v[i])
`endif
    );
  end

  always_comb begin
    conflict  = (|nonred[1:0]) & (|nonred[3:2]);
    offenders = enc_v | seq_v | tim_v | (conflict ? nonred : 4'b0000);
    viol      = |offenders;
    enc_nxt   = (err_encoding & ~clear) | (|enc_v);
    con_nxt   = (err_conflict & ~clear) | conflict;
    seq_nxt   = (err_sequence & ~clear) | (|seq_v);
    tim_nxt   = (err_timing   & ~clear) | (|tim_v);
    dir_nxt   = err_dir;
    if (clear) dir_nxt = 4'b0000;
    // A violation on the clearing edge becomes the new first error.
    if (viol && (clear || !err_any)) dir_nxt = offenders;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_encoding <= 1'b0;
      err_conflict <= 1'b0;
      err_sequence <= 1'b0;
      err_timing   <= 1'b0;
      err_any      <= 1'b0;
      err_dir      <= 4'b0000;
    end else begin
      err_encoding <= enc_nxt;
      err_conflict <= con_nxt;
      err_sequence <= seq_nxt;
      err_timing   <= tim_nxt;
      err_any      <= enc_nxt | con_nxt | seq_nxt | tim_nxt;
      err_dir      <= dir_nxt;
    end
  end

`ifdef TRAFFIC_MON_CYCLE_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt <= 16'd0;
      phase_err <= 1'b0;
    end else if (y2r_v[0]) begin
      if (!phase_err && !viol) cycle_cnt <= cycle_cnt + 16'd1;
      phase_err <= 1'b0;
    end else if (viol) begin
      phase_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed scenarios plus randomized phases vs a colour-rule model.
module tb_traffic_light_monitor;

  localparam int MIN_G = 5;
  localparam int MAX_G = 20;
  localparam int Y_LEN = 3;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear = 1'b0;
  logic [2:0] north_light = R, south_light = R, east_light = R, west_light = R;
  logic       err_encoding, err_conflict, err_sequence, err_timing, err_any;
  logic [3:0] err_dir;
`ifdef TRAFFIC_MON_CYCLE_CNT_EN
  logic [15:0] cycle_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  traffic_light_monitor dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .north_light  (north_light),
    .south_light  (south_light),
    .east_light   (east_light),
    .west_light   (west_light),
    .clear        (clear),
    .err_encoding (err_encoding),
    .err_conflict (err_conflict),
    .err_sequence (err_sequence),
    .err_timing   (err_timing),
    .err_any      (err_any),
    .err_dir      (err_dir)
`ifdef TRAFFIC_MON_CYCLE_CNT_EN
    , .cycle_cnt  (cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Model: colour codes 0=red, 1=green, 2=yellow so the legal successor is (c+1)%3.
  bit         m_known[4];
  int         m_col[4];
  int         m_last[4];
  int         m_dwell[4];
  bit         m_enc, m_con, m_seq, m_tim, m_phase_err;
  logic [3:0] m_dir;
  int         m_cycles;

  function automatic int decode(input logic [2:0] l);
    if (l == R) return 0;
    if (l == G) return 1;
    if (l == Y) return 2;
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      m_known[d] = 1'b0;
      m_col[d]   = 0;
      m_last[d]  = 0;
      m_dwell[d] = 0;
    end
    m_enc = 0; m_con = 0; m_seq = 0; m_tim = 0; m_phase_err = 0;
    m_dir = 4'b0000;
    m_cycles = 0;
  endtask

  task automatic model_clock();
    logic [2:0] l[4];
    bit         enc[4], seq[4], tim[4], nonred[4];
    bit         conflict, any, prior, north_y2r, enc_any, seq_any, tim_any;
    logic [3:0] off;
    int         c, nd;
    if (!reset_n) begin
      model_reset();
      return;
    end
    l = '{north_light, south_light, east_light, west_light};
    north_y2r = 0;
    for (int d = 0; d < 4; d++) begin
      c = decode(l[d]);
      enc[d] = (c < 0);
      seq[d] = 0;
      tim[d] = 0;
      nonred[d] = (l[d] != R);
      if (c >= 0) begin
        nd = (c == m_last[d]) ? m_dwell[d] + 1 : 1;
        if (m_known[d]) begin
          if (c != m_col[d] && c != (m_col[d] + 1) % 3) seq[d] = 1;
          if (m_col[d] == 1 && c == 2 && (m_dwell[d] < MIN_G || m_dwell[d] > MAX_G)) tim[d] = 1;
          if (m_col[d] == 1 && c == 1 && nd == MAX_G + 1) tim[d] = 1;
          if (m_col[d] == 2 && c == 0) begin
            if (m_dwell[d] != Y_LEN) tim[d] = 1;
            if (d == 0) north_y2r = 1;
          end
          m_col[d] = c;
        end else if (c == 0) begin
          m_known[d] = 1;
          m_col[d] = 0;
        end
        m_last[d] = c;
        m_dwell[d] = nd;
      end
    end
    conflict = (nonred[0] || nonred[1]) && (nonred[2] || nonred[3]);
    off = 4'b0000;
    enc_any = 0; seq_any = 0; tim_any = 0;
    for (int d = 0; d < 4; d++) begin
      if (enc[d] || seq[d] || tim[d] || (conflict && nonred[d])) off[d] = 1'b1;
      enc_any |= enc[d];
      seq_any |= seq[d];
      tim_any |= tim[d];
    end
    any = (off != 4'b0000);
    prior = m_enc | m_con | m_seq | m_tim;
    if (clear) begin
      m_enc = 0; m_con = 0; m_seq = 0; m_tim = 0;
      m_dir = 4'b0000;
    end
    if (any && (clear || !prior)) m_dir = off;
    m_enc |= enc_any;
    m_con |= conflict;
    m_seq |= seq_any;
    m_tim |= tim_any;
    if (north_y2r) begin
      if (!m_phase_err && !any) m_cycles = (m_cycles + 1) % 65536;
      m_phase_err = 0;
    end else if (any) begin
      m_phase_err = 1;
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("err_encoding", {15'd0, err_encoding}, {15'd0, m_enc});
    check("err_conflict", {15'd0, err_conflict}, {15'd0, m_con});
    check("err_sequence", {15'd0, err_sequence}, {15'd0, m_seq});
    check("err_timing",   {15'd0, err_timing},   {15'd0, m_tim});
    check("err_any",      {15'd0, err_any},      {15'd0, (m_enc | m_con | m_seq | m_tim)});
    check("err_dir",      {12'd0, err_dir},      {12'd0, m_dir});
`ifdef TRAFFIC_MON_CYCLE_CNT_EN
    check("cycle_cnt", cycle_cnt, m_cycles[15:0]);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    compare_all();
  endtask

  task automatic set_axis(input bit ew, input logic [2:0] col);
    if (ew) begin
      north_light = R; south_light = R; east_light = col; west_light = col;
    end else begin
      north_light = col; south_light = col; east_light = R; west_light = R;
    end
  endtask

  task automatic set_dir(input int d, input logic [2:0] v);
    case (d)
      0: north_light = v;
      1: south_light = v;
      2: east_light  = v;
      default: west_light = v;
    endcase
  endtask

  task automatic axis_phase(input bit ew, input int g, input int yl);
    set_axis(ew, G);
    repeat (g) step();
    set_axis(ew, Y);
    repeat (yl) step();
    set_axis(ew, R);
    repeat (2) step();
  endtask

  task automatic clear_cycle();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic async_reset(input int cycles);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("async_reset_err_any", {15'd0, err_any}, 16'd0);
    check("async_reset_err_dir", {12'd0, err_dir}, 16'd0);
    repeat (cycles) step();
    #2 reset_n = 1'b1;
  endtask

  task automatic run_random(input int phases);
    int  g, yl, rl, d;
    bit  ax;
    logic [2:0] col;
    for (int k = 0; k < phases; k++) begin
      g  = $urandom_range(3, 23);
      yl = $urandom_range(2, 4);
      rl = $urandom_range(1, 3);
      ax = k[0];
      for (int c = 0; c < g + yl + rl; c++) begin
        col = (c < g) ? G : ((c < g + yl) ? Y : R);
        set_axis(ax, col);
        if ($urandom_range(0, 24) == 0) begin
          d = $urandom_range(0, 3);
          set_dir(d, 3'($urandom_range(0, 7)));
        end
        clear = ($urandom_range(0, 19) == 0);
        step();
      end
      clear = 1'b0;
      if ($urandom_range(0, 39) == 0) begin
        set_axis(0, 3'($urandom_range(0, 7)));
        async_reset(2);
      end
    end
  endtask

  initial begin
    model_reset();
    #3;
    compare_all();
    check("reset_err_any", {15'd0, err_any}, 16'd0);
    #9 reset_n = 1'b1;

    set_axis(0, R);
    repeat (3) step();

    // Clean N/S then E/W cycle.
    axis_phase(0, 10, 3);
    axis_phase(1, 10, 3);
    check("clean_cycle_err_any", {15'd0, err_any}, 16'd0);
`ifdef TRAFFIC_MON_CYCLE_CNT_EN
    check("clean_cycle_cnt", cycle_cnt, 16'd1);
`endif

    // Malformed north sample.
    north_light = 3'b011;
    step();
    check("enc_flag", {15'd0, err_encoding}, 16'd1);
    check("enc_dir",  {12'd0, err_dir}, 16'h0001);
    check("enc_any",  {15'd0, err_any}, 16'd1);
    north_light = R;
    step();
    clear_cycle();
    check("after_clear_any", {15'd0, err_any}, 16'd0);

    // Cross-axis conflict.
    north_light = G; east_light = G;
    step();
    check("conflict_flag", {15'd0, err_conflict}, 16'd1);
    check("conflict_dir",  {12'd0, err_dir}, 16'h0005);
    set_axis(0, R);
    step();
    clear_cycle();
    check("after_conflict_clear", {15'd0, err_any}, 16'd0);

    // Short yellow, then green held past the limit.
    north_light = G; repeat (6) step();
    north_light = Y; repeat (2) step();
    north_light = R; step();
    check("short_yellow_timing", {15'd0, err_timing}, 16'd1);
    clear_cycle();
    north_light = G;
    for (int i = 1; i <= 21; i++) begin
      step();
      if (i == 20) check("green20_no_timing", {15'd0, err_timing}, 16'd0);
      if (i == 21) check("green21_timing", {15'd0, err_timing}, 16'd1);
    end
    north_light = Y; repeat (3) step();
    north_light = R; step();
    clear_cycle();

    // Illegal G->R, then clear racing a new east Y->G.
    north_light = G; repeat (6) step();
    north_light = R; step();
    check("g2r_sequence", {15'd0, err_sequence}, 16'd1);
    check("g2r_dir",      {12'd0, err_dir}, 16'h0001);
    east_light = G; repeat (6) step();
    east_light = Y; repeat (2) step();
    east_light = G;
    clear_cycle();
    check("clear_race_seq", {15'd0, err_sequence}, 16'd1);
    check("clear_race_dir", {12'd0, err_dir}, 16'h0004);
    check("clear_race_tim", {15'd0, err_timing}, 16'd0);
    east_light = R; step();
    clear_cycle();

    // Reset in the middle of random traffic.
    for (int i = 0; i < 5; i++) begin
      north_light = 3'($urandom_range(0, 7));
      south_light = 3'($urandom_range(0, 7));
      east_light  = 3'($urandom_range(0, 7));
      west_light  = 3'($urandom_range(0, 7));
      step();
    end
    async_reset(3);
    set_axis(0, R);
    repeat (4) step();
    check("post_reset_quiet", {15'd0, err_any}, 16'd0);

    run_random(150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
